pattern_scan_ctrl: RTL and testbench

- Shares one serial pattern-detector datapath among N_REQ word-sized requesters.
- Each cycle it is idle, it grants one requester round-robin and latches that requester's word.
- It clears the detector, then serializes the word MSB-first onto the detector's din/valid inputs and counts the detector's hit responses.
- At the end of the word it reports the requester id and hit count with a one-cycle done pulse. The block sits between the stream sources and the detector instance.

---
 rtl/pattern_pkg.sv | 29 ++
 rtl/pattern_scan_ctrl_rr_arbiter.sv | 33 +++
 rtl/pattern_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern scan controller and the detector it feeds.
package pattern_pkg;

    // Word width and detector response latency shared with the detector instance.
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DET_LAT = 1;

    // One-hot controller states.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_CLR   = 5'b00010,
        S_SHIFT = 5'b00100,
        S_DRAIN = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_rr_arbiter.sv
// Round-robin grant for the scan controller: picks the first active request
// after the previous winner, wrapping modulo N_REQ. The pointer lives in the caller.
module rr_arbiter
    import pattern_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_last,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_gid,
    output logic             o_valid
);

    // Walk last+1, last+2, ... and latch onto the first request seen.
    always_comb begin
        int idx;
        o_grant = '0;
        o_gid   = '0;
        o_valid = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(i_last) + k) % N_REQ;
            if (!o_valid && i_req[idx]) begin
                o_valid      = 1'b1;
                o_grant[idx] = 1'b1;
                o_gid        = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Time-shares one serial pattern detector among N_REQ word requesters:
// grant round-robin, clear the detector, shift the word out MSB-first,
// count aligned hits, then report the requester id and hit count.
module pattern_scan_ctrl
    import pattern_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  DET_LAT = DEF_DET_LAT,
    localparam int ID_W    = clog2(N_REQ),
    localparam int CNT_W   = clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic                   det_rst,
    output logic                   det_din,
    output logic                   det_valid,
    input  logic                   det_hit,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [CNT_W-1:0]       hit_count
);

    // Drain counter only has to reach DET_LAT (at most 4).
    localparam int DRN_W = 3;

    state_t             r_state;
    logic [ID_W-1:0]    r_last;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_bitcnt;
    logic [CNT_W-1:0]   r_count;
    logic [DRN_W-1:0]   r_drncnt;
    logic [DET_LAT-1:0] r_vld_dly;

    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_gid;
    logic               w_gvalid;
    logic [WIDTH-1:0]   w_word;
    logic               w_vld_del;
    logic [CNT_W-1:0]   w_count_next;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_req   (req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_gid   (w_gid),
        .o_valid (w_gvalid)
    );

    // The ack must coincide with the cycle in which the word is captured,
    // so it is decoded from the registered state rather than registered itself.
    assign ack = (rst && (r_state == S_IDLE)) ? w_grant : '0;

    assign w_word    = req_data[int'(w_gid) * WIDTH +: WIDTH];
    assign w_vld_del = r_vld_dly[DET_LAT-1];

    // A hit only counts when it lines up with a bit actually presented; saturate at WIDTH.
    assign w_count_next = (det_hit && w_vld_del && (r_count < CNT_W'(WIDTH)))
                        ? r_count + CNT_W'(1) : r_count;

    // Delay det_valid by DET_LAT so each hit is paired with the bit that caused it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_dly <= '0;
        end else begin
            for (int i = DET_LAT - 1; i > 0; i--) begin
                r_vld_dly[i] <= r_vld_dly[i-1];
            end
            r_vld_dly[0] <= det_valid;
        end
    end

    // Scan sequencer: IDLE -> CLR -> SHIFT (WIDTH) -> DRAIN (DET_LAT) -> DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_last    <= ID_W'(N_REQ - 1);
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_drncnt  <= '0;
            r_count   <= '0;
            busy      <= 1'b0;
            det_rst   <= 1'b0;
            det_din   <= 1'b0;
            det_valid <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            hit_count <= '0;
        end else begin
            r_count <= w_count_next;
            det_rst <= 1'b0;
            done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gvalid) begin
                        r_last  <= w_gid;
                        r_shreg <= w_word;
                        r_count <= '0;
                        busy    <= 1'b1;
                        det_rst <= 1'b1;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    det_valid <= 1'b1;
                    det_din   <= r_shreg[WIDTH-1];
                    r_shreg   <= r_shreg << 1;
                    r_bitcnt  <= CNT_W'(1);
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_bitcnt == CNT_W'(WIDTH)) begin
                        det_valid <= 1'b0;
                        det_din   <= 1'b0;
                        r_drncnt  <= DRN_W'(1);
                        r_state   <= S_DRAIN;
                    end else begin
                        det_din  <= r_shreg[WIDTH-1];
                        r_shreg  <= r_shreg << 1;
                        r_bitcnt <= r_bitcnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // The response to the last bit lands in the final drain cycle,
                    // so the reported count takes this cycle's increment too.
                    if (r_drncnt == DRN_W'(DET_LAT)) begin
                        done      <= 1'b1;
                        done_id   <= r_last;
                        hit_count <= w_count_next;
                        r_state   <= S_DONE;
                    end else begin
                        r_drncnt <= r_drncnt + DRN_W'(1);
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    det_valid <= 1'b0;
                    det_din   <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: a "101" serial detector stub, a round-robin
// reference model, and a scoreboard monitor checking every completed scan.
module tb_pattern_scan_ctrl;
    import pattern_pkg::*;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int L   = 1;
    localparam int IDW = 2;
    localparam int CW  = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic           busy, det_rst, det_din, det_valid, det_hit, done;
    logic [IDW-1:0] done_id;
    logic [CW-1:0]  hit_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int noise_mode = 0;

    pattern_scan_ctrl #(.N_REQ(N), .WIDTH(W), .DET_LAT(L)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .busy(busy), .det_rst(det_rst), .det_din(det_din), .det_valid(det_valid),
        .det_hit(det_hit), .done(done), .done_id(done_id), .hit_count(hit_count)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Spec rule: first requester after 'last', wrapping.
    function automatic int rr_pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Overlapping occurrences of 1,0,1 in the word read MSB-first.
    function automatic int count_pat(logic [W-1:0] w);
        int c = 0;
        for (int i = W - 1; i >= 2; i--) begin
            if (w[i] && !w[i-1] && w[i-2]) c++;
        end
        return c;
    endfunction

    function automatic logic noise_bit();
        if (noise_mode == 2) return 1'b1;
        if (noise_mode == 1) return 1'($urandom % 2);
        return 1'b0;
    endfunction

    // Detector stub: matches 1,0,1 since its last clear, answering L cycles
    // after each valid bit; while no bit is due it may drive junk levels.
    logic [2:0]   stub_sr   = '0;
    int           stub_n    = 0;
    logic [L-1:0] stub_pipe = '0;
    initial det_hit = 1'b0;
    always @(negedge clk) begin
        logic nxt;
        det_hit = stub_pipe[L-1];
        for (int i = L - 1; i > 0; i--) stub_pipe[i] = stub_pipe[i-1];
        if (det_rst) begin
            stub_sr = '0;
            stub_n  = 0;
            nxt     = noise_bit();
        end else if (det_valid) begin
            stub_sr = {stub_sr[1:0], det_din};
            stub_n++;
            nxt = (stub_n >= 3) && (stub_sr == 3'b101);
        end else begin
            nxt = noise_bit();
        end
        stub_pipe[0] = nxt;
    end

    typedef struct {
        int         id;
        logic [W-1:0] word;
        int         exp_cnt;
        int         t_ack;
    } scan_t;

    scan_t        sbq[$];
    bit           m_busy  = 0;
    int           m_last  = N - 1;
    int           last_id = 0;
    int           last_cnt = 0;
    logic [W-1:0] m_bits  = '0;
    int           m_nbits = 0;
    int           m_nrst  = 0;
    int           m_first_vld = -1;

    // Monitor: predicts ack from the RR model, scores every done against the queue.
    always @(negedge clk) begin
        scan_t        s;
        int           g;
        logic [N-1:0] exp_ack;
        if (!rst) begin
            chk("reset_outputs", 64'({ack, busy, det_rst, det_din, det_valid, done, done_id, hit_count}), 64'(0));
            sbq.delete();
            m_busy = 0; m_last = N - 1; last_id = 0; last_cnt = 0;
            m_bits = '0; m_nbits = 0; m_nrst = 0; m_first_vld = -1;
        end else begin
            chk("busy", 64'(busy), 64'(m_busy));
            exp_ack = '0;
            g = -1;
            if (!m_busy) begin
                g = rr_pick(req, m_last);
                if (g >= 0) exp_ack[g] = 1'b1;
            end
            if (exp_ack != '0 || ack != '0) chk("ack", 64'(ack), 64'(exp_ack));
            if (m_busy) begin
                if (det_rst) m_nrst++;
                if (det_valid) begin
                    if (m_nbits == 0) m_first_vld = cyc;
                    m_bits = {m_bits[W-2:0], det_din};
                    m_nbits++;
                end
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("done_unexpected", 64'(1), 64'(0));
                end else begin
                    s = sbq.pop_front();
                    chk("done_id", 64'(done_id), 64'(s.id));
                    chk("hit_count", 64'(hit_count), 64'(s.exp_cnt));
                    chk("done_latency", 64'(cyc - s.t_ack), 64'(W + L + 2));
                    chk("first_bit_latency", 64'(m_first_vld - s.t_ack), 64'(2));
                    chk("bit_count", 64'(m_nbits), 64'(W));
                    chk("din_sequence", 64'(m_bits), 64'(s.word));
                    chk("det_rst_pulses", 64'(m_nrst), 64'(1));
                    last_id = s.id;
                    last_cnt = s.exp_cnt;
                end
                m_busy = 0;
            end else begin
                chk("done_id_hold", 64'(done_id), 64'(last_id));
                chk("hit_count_hold", 64'(hit_count), 64'(last_cnt));
            end
            if (g >= 0 && ack == exp_ack) begin
                s.id = g;
                s.word = req_data[g*W +: W];
                s.exp_cnt = count_pat(s.word);
                s.t_ack = cyc;
                sbq.push_back(s);
                m_busy = 1; m_last = g;
                m_bits = '0; m_nbits = 0; m_nrst = 0; m_first_vld = -1;
            end
        end
    end

    task automatic wait_ack(input int id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[id] && n < 200);
        if (!ack[id]) chk("ack_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_any_ack(output int got);
        int n = 0;
        got = -1;
        while (got < 0 && n < 200) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) if (ack[i]) got = i;
        end
        if (got < 0) chk("ack_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        if (!done) chk("done_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) chk("idle_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic scan(input int id, input logic [W-1:0] w);
        req_data[id*W +: W] = w;
        req[id] = 1'b1;
        wait_ack(id);
        @(posedge clk); #1;
        req[id] = 1'b0;
        wait_done();
    endtask

    // Safety net in case the design wedges outside any bounded wait.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Main stimulus sequence.
    initial begin
        int got;
        int rr_got[5];
        int rr_t[5];
        rst = 1'b1; req = '0; req_data = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Directed scans: mixed word, held hit after the last response, empty word.
        scan(0, 16'hA5A5);
        noise_mode = 2;
        scan(1, 16'h0005);
        noise_mode = 1;
        scan(2, 16'h0000);
        scan(3, 16'hB6DB);

        // Round-robin with every requester holding req.
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_any_ack(got);
            rr_got[k] = got;
            rr_t[k] = cyc;
            @(posedge clk); #1;
            if (got >= 0) req_data[got*W +: W] = W'($urandom);
        end
        req = '0;
        wait_idle();
        for (int k = 0; k < 5; k++) chk("rr_order", 64'(rr_got[k]), 64'(k % N));
        for (int k = 0; k < 4; k++) chk("rr_spacing", 64'(rr_t[k+1] - rr_t[k]), 64'(W + L + 3));

        // Contention: 1 granted, then 3 and 1 both request mid-scan.
        req_data[1*W +: W] = 16'h5A5A;
        req[1] = 1'b1;
        wait_ack(1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        req_data[3*W +: W] = 16'hDEAD;
        req_data[1*W +: W] = 16'hAAAA;
        req[3] = 1'b1; req[1] = 1'b1;
        wait_any_ack(got);
        chk("contention_first", 64'(got), 64'(3));
        @(posedge clk); #1;
        req[3] = 1'b0;
        wait_any_ack(got);
        chk("contention_second", 64'(got), 64'(1));
        @(posedge clk); #1;
        req[1] = 1'b0;
        wait_idle();

        // Random request traffic, including withdrawals and held requests.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom % 6 == 0) req[i] = ~req[i];
                if ($urandom % 3 == 0) req_data[i*W +: W] = W'($urandom);
            end
            @(posedge clk); #1;
        end
        req = '0;
        wait_idle();

        // Asynchronous reset in the middle of shifting an all-ones word.
        req_data[0 +: W] = 16'hFFFF;
        req[0] = 1'b1;
        wait_ack(0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!det_valid && n < 50);
            if (!det_valid) chk("shift_timeout", 64'(0), 64'(1));
        end
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset", 64'({ack, busy, det_rst, det_din, det_valid, done, done_id, hit_count}), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        req_data[2*W +: W] = 16'h3C5A;
        req = 4'b0100;
        @(negedge clk);
        chk("ack_after_reset", 64'(ack), 64'(4'b0100));
        @(posedge clk); #1;
        req = '0;
        wait_done();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
